// File: rtl/mux_out_buf.sv
// Output flit buffer behind the 2:1 router mux: framing check on write, DEPTH-entry FIFO
// toward the link, and delivered packet/flit counters for activity correlation.
module mux_out_buf #(
  parameter int DATAW = 66,
  parameter int VCHW  = 2,
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [DATAW-1:0] idata,
  input  logic             ivalid,
  input  logic [VCHW-1:0]  ivch,
  output logic             iready,
  output logic [DATAW-1:0] odata,
  output logic             ovalid,
  output logic [VCHW-1:0]  ovch,
  input  logic             oready,
  output logic [CNTW-1:0]  pkt_cnt,
  output logic [CNTW-1:0]  flit_cnt,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  localparam logic [1:0] NONE = 2'b00;
  localparam logic [1:0] HEAD = 2'b01;
  localparam logic [1:0] DATA = 2'b10;
  localparam logic [1:0] TAIL = 2'b11;

  typedef enum logic {IDLE, BODY} state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      occ;
  logic [DATAW-1:0] data_mem [DEPTH];
  logic [VCHW-1:0]  vch_mem  [DEPTH];

  logic       push, pop, err_set;
  logic [1:0] in_type;

  assign in_type = idata[DATAW-1 -: 2];
  assign iready  = (occ != FULL);
  assign ovalid  = (occ != '0);
  assign pop     = ovalid && oready;

  // Empty entries are masked so the link sees zeros while nothing is queued.
  assign odata = ovalid ? data_mem[rd_ptr] : '0;
  assign ovch  = ovalid ? vch_mem[rd_ptr]  : '0;

  always_comb begin
    push      = 1'b0;
    err_set   = 1'b0;
    state_nxt = state;
    if (ivalid && iready) begin
      case (state)
        IDLE: begin
          case (in_type)
            HEAD: begin
              push      = 1'b1;
              state_nxt = BODY;
            end
            DATA, TAIL: err_set = 1'b1;
            default: ;
          endcase
        end
        BODY: begin
          case (in_type)
            DATA: push = 1'b1;
            TAIL: begin
              push      = 1'b1;
              state_nxt = IDLE;
            end
            HEAD: begin
              push    = 1'b1;
              err_set = 1'b1;
            end
            default: ;
          endcase
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      pkt_cnt  <= '0;
      flit_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
      if (pop) begin
        flit_cnt <= flit_cnt + CNTW'(1);
        if (odata[DATAW-1 -: 2] == TAIL) pkt_cnt <= pkt_cnt + CNTW'(1);
      end
      if (err_set) err <= 1'b1;
    end
  end

  // Storage is datapath only; the occupancy count guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= idata;
      vch_mem[wr_ptr]  <= ivch;
    end
  end

endmodule

// File: tb/tb_mux_out_buf.sv
// Directed bench for mux_out_buf: streaming, backpressure, framing errors, pointer wrap,
// asynchronous reset and counter wrap, all against hand-computed expectations.
module tb_mux_out_buf;

  localparam int DATAW = 66;
  localparam int VCHW  = 2;
  localparam int DEPTH = 4;
  localparam int CNTW  = 16;

  localparam logic [1:0] T_NONE = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_DATA = 2'b10;
  localparam logic [1:0] T_TAIL = 2'b11;

  logic             clk = 1'b0;
  logic             rst_;
  logic [DATAW-1:0] idata;
  logic             ivalid;
  logic [VCHW-1:0]  ivch;
  logic             iready;
  logic [DATAW-1:0] odata;
  logic             ovalid;
  logic [VCHW-1:0]  ovch;
  logic             oready;
  logic [CNTW-1:0]  pkt_cnt;
  logic [CNTW-1:0]  flit_cnt;
  logic             err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATAW-1:0] held [5];

  mux_out_buf #(.DATAW(DATAW), .VCHW(VCHW), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst_(rst_),
    .idata(idata), .ivalid(ivalid), .ivch(ivch), .iready(iready),
    .odata(odata), .ovalid(ovalid), .ovch(ovch), .oready(oready),
    .pkt_cnt(pkt_cnt), .flit_cnt(flit_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATAW-1:0] got, input logic [DATAW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATAW-1:0] mk(input logic [1:0] t, input int pl);
    return {t, 64'(pl)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_   = 1'b0;
    idata  = '0;
    ivalid = 1'b0;
    ivch   = '0;
    oready = 1'b0;
    #12;
    check("rst_ovalid", 66'(ovalid), 66'(0));
    check("rst_iready", 66'(iready), 66'(1));
    check("rst_odata",  odata, '0);
    check("rst_ovch",   66'(ovch), 66'(0));
    check("rst_cnts",   66'({pkt_cnt, flit_cnt}), 66'(0));
    check("rst_err",    66'(err), 66'(0));
    rst_ = 1'b1;
    tick();

    // Stream HEAD, 20 DATA, TAIL on VC 1 with the link always ready.
    ivch   = 2'd1;
    oready = 1'b1;
    for (int i = 0; i < 22; i++) begin
      idata  = mk(i == 0 ? T_HEAD : (i == 21 ? T_TAIL : T_DATA), 100 + i);
      ivalid = 1'b1;
      tick();
      check("s1_odata",  odata, mk(i == 0 ? T_HEAD : (i == 21 ? T_TAIL : T_DATA), 100 + i));
      check("s1_ovch",   66'(ovch), 66'(1));
      check("s1_ovalid", 66'(ovalid), 66'(1));
    end
    ivalid = 1'b0;
    tick();
    check("s1_drained", 66'(ovalid), 66'(0));
    check("s1_flit_cnt", 66'(flit_cnt), 66'(22));
    check("s1_pkt_cnt",  66'(pkt_cnt), 66'(1));
    check("s1_err",      66'(err), 66'(0));

    // Backpressure: five flits offered with the link stalled.
    oready = 1'b0;
    ivch   = 2'd2;
    for (int k = 0; k < 5; k++) held[k] = mk(k == 0 ? T_HEAD : T_DATA, 200 + k);
    for (int k = 0; k < 5; k++) begin
      idata  = held[k];
      ivalid = 1'b1;
      check("s2_iready_pre", 66'(iready), 66'(k < 4 ? 1 : 0));
      if (k < 4) tick();
    end
    tick();
    check("s2_held_full", 66'(iready), 66'(0));
    check("s2_head", odata, held[0]);
    oready = 1'b1;
    check("s2_pop_cycle_iready", 66'(iready), 66'(0));
    tick();
    check("s2_iready_back", 66'(iready), 66'(1));
    check("s2_next_head", odata, held[1]);
    oready = 1'b0;
    tick();
    check("s2_refull", 66'(iready), 66'(0));
    ivalid = 1'b0;
    oready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      check("s2_drain_order", odata, held[k]);
      check("s2_drain_vch", 66'(ovch), 66'(2));
      tick();
    end
    check("s2_empty", 66'(ovalid), 66'(0));
    check("s2_flit_cnt", 66'(flit_cnt), 66'(27));
    idata  = mk(T_TAIL, 205);
    ivalid = 1'b1;
    tick();
    check("s2_tail", odata, mk(T_TAIL, 205));
    ivalid = 1'b0;
    tick();
    check("s2_pkt_cnt", 66'(pkt_cnt), 66'(2));
    check("s2_flit_cnt_end", 66'(flit_cnt), 66'(28));

    // DATA while idle is a framing error and is dropped.
    idata  = mk(T_DATA, 300);
    ivalid = 1'b1;
    tick();
    check("s3_drop_ovalid", 66'(ovalid), 66'(0));
    check("s3_err", 66'(err), 66'(1));
    idata = mk(T_HEAD, 301);
    tick();
    check("s3_head_acc", odata, mk(T_HEAD, 301));
    check("s3_err_sticky", 66'(err), 66'(1));
    idata = mk(T_TAIL, 302);
    tick();
    ivalid = 1'b0;
    tick();
    check("s3_flit_cnt", 66'(flit_cnt), 66'(30));
    check("s3_pkt_cnt",  66'(pkt_cnt), 66'(3));

    // Alternate single push and single pop across three pointer wraps.
    ivch = 2'd3;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      idata  = mk(i == 0 ? T_HEAD : (i == 3 * DEPTH - 1 ? T_TAIL : T_DATA), 400 + i);
      ivalid = 1'b1;
      oready = 1'b0;
      tick();
      check("s4_order", odata, mk(i == 0 ? T_HEAD : (i == 3 * DEPTH - 1 ? T_TAIL : T_DATA), 400 + i));
      check("s4_vch", 66'(ovch), 66'(3));
      ivalid = 1'b0;
      oready = 1'b1;
      tick();
      check("s4_occ_le1", 66'(ovalid), 66'(0));
    end
    check("s4_flit_cnt", 66'(flit_cnt), 66'(42));
    check("s4_pkt_cnt",  66'(pkt_cnt), 66'(4));

    // Asynchronous reset with three flits of an open packet stored.
    oready = 1'b0;
    ivch   = 2'd1;
    for (int i = 0; i < 3; i++) begin
      idata  = mk(i == 0 ? T_HEAD : T_DATA, 500 + i);
      ivalid = 1'b1;
      tick();
    end
    ivalid = 1'b0;
    check("s5_stored", 66'(ovalid), 66'(1));
    #2;
    rst_ = 1'b0;
    #1;
    check("s5_async_ovalid", 66'(ovalid), 66'(0));
    check("s5_async_iready", 66'(iready), 66'(1));
    check("s5_async_odata",  odata, '0);
    check("s5_async_cnts",   66'({pkt_cnt, flit_cnt}), 66'(0));
    check("s5_async_err",    66'(err), 66'(0));
    #1;
    rst_ = 1'b1;
    idata  = mk(T_DATA, 510);
    ivalid = 1'b1;
    tick();
    check("s5_data_drop", 66'(ovalid), 66'(0));
    check("s5_data_err",  66'(err), 66'(1));
    ivalid = 1'b0;

    // Counter wrap: one long packet of 65535 flits, then one more flit.
    #1;
    rst_ = 1'b0;
    #1;
    rst_ = 1'b1;
    oready = 1'b1;
    ivalid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      idata = mk(i == 0 ? T_HEAD : (i == 65534 ? T_TAIL : T_DATA), i);
      tick();
    end
    ivalid = 1'b0;
    tick();
    check("s6_flit_cnt_max", 66'(flit_cnt), 66'(65535));
    check("s6_pkt_cnt",      66'(pkt_cnt), 66'(1));
    check("s6_err_clean",    66'(err), 66'(0));
    idata  = mk(T_NONE, 7);
    ivalid = 1'b1;
    tick();
    check("s6_none_idle_ovalid", 66'(ovalid), 66'(0));
    check("s6_none_idle_err",    66'(err), 66'(0));
    idata = mk(T_HEAD, 8);
    tick();
    check("s6_last_head", odata, mk(T_HEAD, 8));
    idata = mk(T_NONE, 9);
    tick();
    check("s6_none_body_ovalid", 66'(ovalid), 66'(0));
    check("s6_none_body_err",    66'(err), 66'(0));
    check("s6_flit_cnt_wrap",    66'(flit_cnt), 66'(0));
    check("s6_pkt_cnt_end",      66'(pkt_cnt), 66'(1));
    ivalid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
